// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// master: requesters plus memory (drives requests and memory responses); slave: the arbiter.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_wr;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    ack;
    logic                  err;
    logic [31:0]           resp_rdata;
    logic                  busy;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport master (
        output req, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
        input  ack, err, resp_rdata, busy, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req, req_wr, req_addr, req_wdata, mem_rdata, mem_ready,
        output ack, err, resp_rdata, busy, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters, one access at a time,
// with wait states via mem_ready and an optional timeout abort. All outputs are registered.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = PW + 1;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]      grant, grant_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic               err_q, err_nxt;
    logic               busy_q, busy_nxt;
    logic               rd_q, rd_nxt;
    logic               wr_q, wr_nxt;
    logic [31:0]        addr_q, addr_nxt;
    logic [31:0]        wdata_q, wdata_nxt;
    logic [31:0]        rdata_q, rdata_nxt;

    logic               pick_found;
    logic [PW-1:0]      pick_idx;
    logic [SW-1:0]      cand_sum;
    logic [PW-1:0]      cand;

    // Search rr_ptr, rr_ptr+1, ... with an explicit wrap so non-power-of-two counts work too.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand_sum   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + SW'(i);
            if (cand_sum >= SW'(NUM_REQ)) begin
                cand_sum = cand_sum - SW'(NUM_REQ);
            end
            cand = cand_sum[PW-1:0];
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant;
        cnt_nxt    = cnt;
        ack_nxt    = '0;
        err_nxt    = 1'b0;
        busy_nxt   = busy_q;
        rd_nxt     = rd_q;
        wr_nxt     = wr_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        rdata_nxt  = rdata_q;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    addr_nxt  = bus.req_addr[32*pick_idx +: 32];
                    wdata_nxt = bus.req_wdata[32*pick_idx +: 32];
                    rd_nxt    = ~bus.req_wr[pick_idx];
                    wr_nxt    = bus.req_wr[pick_idx];
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
                // mem_ready takes priority over a timeout landing in the same cycle.
                if (bus.mem_ready) begin
                    if (rd_q) begin
                        rdata_nxt = bus.mem_rdata;
                    end
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    ack_nxt   = NUM_REQ'(1) << grant;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    ack_nxt   = NUM_REQ'(1) << grant;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rr_ptr_nxt = (grant == LAST_REQ) ? '0 : grant + PW'(1);
                cnt_nxt    = '0;
                busy_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            grant   <= '0;
            cnt     <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            rr_ptr  <= rr_ptr_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            busy_q  <= busy_nxt;
            rd_q    <= rd_nxt;
            wr_q    <= wr_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.mem_rd     = rd_q;
    assign bus.mem_wr     = wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.resp_rdata = rdata_q;
endmodule
